// File: rtl/pool_window_feeder_pkg.sv
// Shared types and constants for the pooling window feeder.
// Holds the FSM state encoding, window geometry and the pooler watchdog limit.
package pool_window_feeder_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  localparam int WIN           = 4;
  localparam int WIN_ELEMS     = WIN * WIN;
  localparam int TIMEOUT_LIMIT = 64;
  localparam int TIMEOUT_W     = $clog2(TIMEOUT_LIMIT);

endpackage

// File: rtl/pool_window_feeder_if.sv
// Pixel input, pooler window/result and pooled output handshakes of the feeder.
// master = feeder side, slave = surrounding logic (pixel source, pooler, sink).
interface pool_window_feeder_if #(
  parameter int DW = 22
);
  import pool_window_feeder_pkg::*;

  logic                      in_valid;
  logic signed [DW-1:0]      in_data;
  logic                      in_ready;
  logic                      pool_en;
  logic [WIN_ELEMS*DW-1:0]   win_data;
  logic                      pool_done;
  logic signed [DW-1:0]      pool_res;
  logic                      res_valid;
  logic signed [DW-1:0]      res_data;
  logic                      res_ready;

  modport master (
    input  in_valid, in_data, pool_done, pool_res, res_ready,
    output in_ready, pool_en, win_data, res_valid, res_data
  );

  modport slave (
    output in_valid, in_data, pool_done, pool_res, res_ready,
    input  in_ready, pool_en, win_data, res_valid, res_data
  );

endinterface

// File: rtl/pool_window_feeder_band_buf.sv
// pool_band_buf: 4-row band store, one row-major write port, combinational 4x4 column-group read.
// Latency: write lands on the clock edge, read is same-cycle; no backpressure of its own.
module pool_band_buf
  import pool_window_feeder_pkg::*;
#(
  parameter int DW    = 22,
  parameter int IMG_W = 16,
  parameter int AW    = $clog2(WIN * IMG_W),
  parameter int GW    = (IMG_W / WIN > 1) ? $clog2(IMG_W / WIN) : 1
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [DW-1:0]           wr_data,
  input  logic [GW-1:0]           rd_grp,
  output logic [WIN_ELEMS*DW-1:0] rd_win
);

  logic [DW-1:0] mem [WIN*IMG_W];
  logic [AW-1:0] col_base;

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign col_base = AW'(rd_grp) * AW'(WIN);

  for (genvar k = 0; k < WIN_ELEMS; k++) begin : g_rd
    assign rd_win[k*DW +: DW] = mem[col_base + AW'((k / WIN) * IMG_W + (k % WIN))];
  end

endmodule

// File: rtl/pool_window_feeder.sv
// Buffers a 4-row band, then feeds non-overlapping 4x4 windows to a pooler; 1 cycle pixel->pool_en and pool_done->res_valid.
// in_ready drops for the whole drain of a band; POOL_FEEDER_TIMEOUT_EN adds a sticky 64-cycle pooler watchdog on err.
module pool_window_feeder
  import pool_window_feeder_pkg::*;
#(
  parameter int DW    = 22,
  parameter int IMG_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pool_window_feeder_if.master bus,
  output logic                 err
);

  localparam int NPIX = WIN * IMG_W;
  localparam int AW   = $clog2(NPIX);
  localparam int NGRP = IMG_W / WIN;
  localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam logic [AW-1:0] PIX_LAST = AW'(NPIX - 1);
  localparam logic [GW-1:0] GRP_LAST = GW'(NGRP - 1);

  state_t                  state, state_nxt;
  logic [AW-1:0]           pix_cnt;
  logic [GW-1:0]           grp_idx;
  logic signed [DW-1:0]    res_q;
  logic [WIN_ELEMS*DW-1:0] win;
  logic                    pix_acc;
  logic                    pool_hit;
  logic                    res_hs;
  logic                    tmo_hit;

  assign pix_acc  = (state == ST_FILL) && bus.in_valid;
  assign pool_hit = (state == ST_WAIT) && bus.pool_done;
  assign res_hs   = (state == ST_OUT) && bus.res_ready;

`ifdef POOL_FEEDER_TIMEOUT_EN
  localparam logic signed [DW-1:0] RES_MIN = {1'b1, {(DW-1){1'b0}}};
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic                 err_q;

  assign tmo_hit = (state == ST_WAIT) && !bus.pool_done &&
                   (tmo_cnt == TIMEOUT_W'(TIMEOUT_LIMIT - 1));
  assign err     = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      tmo_cnt <= (state == ST_WAIT) ? tmo_cnt + TIMEOUT_W'(1) : '0;
      if (tmo_hit) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  pool_band_buf #(
    .DW    (DW),
    .IMG_W (IMG_W)
  ) u_band_buf (
    .clk     (clk),
    .wr_en   (pix_acc),
    .wr_addr (pix_cnt),
    .wr_data (bus.in_data),
    .rd_grp  (grp_idx),
    .rd_win  (win)
  );

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.pool_en   = 1'b0;
    bus.res_valid = 1'b0;
    bus.win_data  = win;
    bus.res_data  = res_q;
    case (state)
      ST_FILL: begin
        bus.in_ready = 1'b1;
        if (pix_acc && pix_cnt == PIX_LAST) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        bus.pool_en = 1'b1;
        state_nxt   = ST_WAIT;
      end
      ST_WAIT: begin
        bus.pool_en = 1'b1;
        if (bus.pool_done || tmo_hit) state_nxt = ST_OUT;
      end
      ST_OUT: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) state_nxt = (grp_idx == GRP_LAST) ? ST_FILL : ST_ISSUE;
      end
      default: state_nxt = ST_FILL;
    endcase
  end

  // pix_cnt doubles as the row-major write address inside the band.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_FILL;
      pix_cnt <= '0;
      grp_idx <= '0;
      res_q   <= '0;
    end else begin
      state <= state_nxt;
      if (pix_acc) begin
        pix_cnt <= (pix_cnt == PIX_LAST) ? '0 : pix_cnt + AW'(1);
      end
      if (pix_acc && pix_cnt == PIX_LAST) begin
        grp_idx <= '0;
      end else if (res_hs) begin
        grp_idx <= (grp_idx == GRP_LAST) ? '0 : grp_idx + GW'(1);
      end
      if (pool_hit) begin
        res_q <= bus.pool_res;
      end
`ifdef POOL_FEEDER_TIMEOUT_EN
      else if (tmo_hit) begin
        res_q <= RES_MIN;
      end
`endif
    end
  end

endmodule

// File: tb/tb_pool_window_feeder.sv
// Bench for pool_window_feeder: random bands against a row-major window/max reference model,
// with handshake, backpressure, reset and pooler-timeout scenarios.
module tb_pool_window_feeder;

  localparam int DW        = 22;
  localparam int IMG_W     = 8;
  localparam int NPIX      = 4 * IMG_W;
  localparam int NWIN      = IMG_W / 4;
  localparam int WELEMS    = 16;
  localparam logic signed [DW-1:0] MIN_VAL = {1'b1, {(DW-1){1'b0}}};

  logic clk = 1'b0;
  logic rst_n;
  logic err;

  always #5 clk = ~clk;

  pool_window_feeder_if #(.DW(DW)) bus ();

  pool_window_feeder #(
    .DW    (DW),
    .IMG_W (IMG_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .err   (err)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic signed [DW-1:0] band [NPIX];

  function automatic logic signed [DW-1:0] model_elem(int w, int k);
    return band[(k / 4) * IMG_W + 4 * w + (k % 4)];
  endfunction

  function automatic logic [WELEMS*DW-1:0] model_win(int w);
    logic [WELEMS*DW-1:0] v;
    v = '0;
    for (int k = 0; k < WELEMS; k++) v[k*DW +: DW] = model_elem(w, k);
    return v;
  endfunction

  function automatic logic signed [DW-1:0] model_max(int w);
    logic signed [DW-1:0] m;
    m = model_elem(w, 0);
    for (int k = 1; k < WELEMS; k++) if (model_elem(w, k) > m) m = model_elem(w, k);
    return m;
  endfunction

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.pool_done = 1'b0;
    bus.pool_res  = '0;
    bus.res_ready = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < NPIX; i++) band[i] = DW'($urandom);
  endtask

  // Drives the first n pixels of band with random gaps; stray pool_done pulses are ignored in FILL.
  task automatic send_band(input int n, input int gap_pct);
    int i;
    i = 0;
    while (i < n) begin
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
        n_errors++;
        $display("FAIL fill_in_ready pix %0d: got %b want 1", i, bus.in_ready);
      end
      if (int'($urandom_range(99)) < gap_pct) begin
        bus.in_valid = 1'b0;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = band[i];
        i++;
      end
      bus.pool_done = 1'($urandom_range(1));
      bus.pool_res  = DW'($urandom);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.pool_done = 1'b0;
    if (n == NPIX) begin
      n_checks++;
      if (bus.pool_en !== 1'b1 || bus.in_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL issue_latency: pool_en=%b in_ready=%b want 1/0", bus.pool_en, bus.in_ready);
      end
    end
  endtask

  // Entered at the negedge where window w should be presented (ISSUE).
  task automatic serve_window(input int w, input int delay, input int hold, input bit garbage,
                              output logic signed [DW-1:0] got);
    logic [WELEMS*DW-1:0] exp_win;
    logic signed [DW-1:0] exp_res;
    exp_win = model_win(w);
    exp_res = model_max(w);
    n_checks++;
    if (bus.pool_en !== 1'b1 || bus.win_data !== exp_win) begin
      n_errors++;
      $display("FAIL issue_win%0d: pool_en=%b win=%h want 1 %h", w, bus.pool_en, bus.win_data, exp_win);
    end
    if (garbage) begin
      bus.pool_done = 1'b1;
      bus.pool_res  = ~exp_res;
    end
    for (int c = 1; c <= delay; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.pool_en !== 1'b1 || bus.win_data !== exp_win || bus.in_ready !== 1'b0 ||
          bus.res_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL wait_hold win%0d c%0d: pool_en=%b in_ready=%b res_valid=%b win=%h want 1/0/0 %h",
                 w, c, bus.pool_en, bus.in_ready, bus.res_valid, bus.win_data, exp_win);
      end
      bus.pool_done = (c == delay);
      bus.pool_res  = (c == delay) ? exp_res : ~exp_res;
    end
    @(negedge clk);
    bus.pool_done = 1'b0;
    got = bus.res_data;
    n_checks++;
    if (bus.res_valid !== 1'b1 || bus.pool_en !== 1'b0 || bus.res_data !== exp_res) begin
      n_errors++;
      $display("FAIL result_win%0d: res_valid=%b pool_en=%b res_data=%0d want 1/0 %0d",
               w, bus.res_valid, bus.pool_en, bus.res_data, exp_res);
    end
    for (int c = 0; c < hold; c++) begin
      bus.res_ready = 1'b0;
      if (garbage) begin
        bus.pool_done = 1'($urandom_range(1));
        bus.pool_res  = ~exp_res;
      end
      @(negedge clk);
      n_checks++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== exp_res || bus.pool_en !== 1'b0 ||
          bus.in_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL out_hold win%0d c%0d: res_valid=%b res_data=%0d pool_en=%b in_ready=%b want 1 %0d 0 0",
                 w, c, bus.res_valid, bus.res_data, bus.pool_en, bus.in_ready, exp_res);
      end
    end
    bus.res_ready = 1'b1;
    bus.pool_done = 1'b0;
    @(negedge clk);
    bus.res_ready = 1'b0;
    n_checks++;
    if (w < NWIN - 1) begin
      if (bus.pool_en !== 1'b1 || bus.in_ready !== 1'b0 || bus.res_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL next_issue win%0d: pool_en=%b in_ready=%b res_valid=%b want 1/0/0",
                 w, bus.pool_en, bus.in_ready, bus.res_valid);
      end
    end else begin
      if (bus.pool_en !== 1'b0 || bus.in_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL back_to_fill: pool_en=%b in_ready=%b res_valid=%b want 0/1/0",
                 bus.pool_en, bus.in_ready, bus.res_valid);
      end
    end
  endtask

  task automatic run_band(input int gap_pct, input bit garbage);
    logic signed [DW-1:0] got;
    send_band(NPIX, gap_pct);
    for (int w = 0; w < NWIN; w++) begin
      serve_window(w, int'($urandom_range(1, 5)), int'($urandom_range(0, 3)), garbage, got);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.pool_en !== 1'b0 || bus.res_valid !== 1'b0 || bus.res_data !== '0 || err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: pool_en=%b res_valid=%b res_data=%0d err=%b want 0/0/0/0",
               bus.pool_en, bus.res_valid, bus.res_data, err);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_ramp();
    logic signed [DW-1:0] got0, got1;
    for (int i = 0; i < NPIX; i++) band[i] = DW'(i);
    send_band(NPIX, 0);
    serve_window(0, 3, 0, 1'b0, got0);
    serve_window(1, 3, 0, 1'b0, got1);
    n_checks++;
    if (got0 !== DW'(27) || got1 !== DW'(31)) begin
      n_errors++;
      $display("FAIL ramp_results: got %0d,%0d want 27,31", got0, got1);
    end
  endtask

  task automatic test_negative();
    logic signed [DW-1:0] got0, got1;
    for (int i = 0; i < NPIX; i++) band[i] = DW'(-5);
    band[int'($urandom_range(0, 3)) * IMG_W + int'($urandom_range(0, 3))] = DW'(-1);
    send_band(NPIX, 20);
    serve_window(0, 2, 1, 1'b1, got0);
    serve_window(1, 1, 0, 1'b1, got1);
    n_checks++;
    if ($signed(got0) != -1 || $signed(got1) != -5) begin
      n_errors++;
      $display("FAIL negative_results: got %0d,%0d want -1,-5", $signed(got0), $signed(got1));
    end
  endtask

  task automatic test_backpressure();
    logic signed [DW-1:0] got;
    fill_random();
    send_band(NPIX, 0);
    serve_window(0, 2, 10, 1'b1, got);
    serve_window(1, 4, 10, 1'b0, got);
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 2; b++) begin
      fill_random();
      run_band(0, 1'b0);
    end
  endtask

  task automatic test_random();
    for (int b = 0; b < 4; b++) begin
      fill_random();
      run_band(30, 1'b1);
    end
  endtask

  task automatic test_reset_wait();
    fill_random();
    send_band(NPIX, 10);
    repeat (2) @(negedge clk);
    bus.pool_done = 1'b1;
    bus.pool_res  = DW'($urandom);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.pool_en !== 1'b0 || bus.res_valid !== 1'b0 || bus.res_data !== '0) begin
      n_errors++;
      $display("FAIL reset_in_wait: pool_en=%b res_valid=%b res_data=%0d want 0/0/0",
               bus.pool_en, bus.res_valid, bus.res_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.pool_en !== 1'b0 || bus.res_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL after_reset: in_ready=%b pool_en=%b res_valid=%b want 1/0/0",
               bus.in_ready, bus.pool_en, bus.res_valid);
    end
    bus.pool_done = 1'b0;
    fill_random();
    run_band(10, 1'b0);
  endtask

  task automatic test_reset_fill();
    fill_random();
    send_band(13, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    fill_random();
    run_band(0, 1'b0);
  endtask

  task automatic test_timeout();
    logic signed [DW-1:0] got;
    int cyc;
    fill_random();
    send_band(NPIX, 0);
`ifdef POOL_FEEDER_TIMEOUT_EN
    cyc = 0;
    while (bus.res_valid !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc != 65 || err !== 1'b1 || bus.res_data !== MIN_VAL || $signed(bus.res_data) != -2097152) begin
      n_errors++;
      $display("FAIL timeout: cycles=%0d err=%b res_data=%0d want 65 1 -2097152",
               cyc, err, $signed(bus.res_data));
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    n_checks++;
    if (bus.pool_en !== 1'b1 || err !== 1'b1) begin
      n_errors++;
      $display("FAIL timeout_next: pool_en=%b err=%b want 1/1", bus.pool_en, err);
    end
    serve_window(1, 2, 0, 1'b0, got);
`else
    cyc = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (bus.pool_en !== 1'b1 || bus.res_valid !== 1'b0 || err !== 1'b0) cyc++;
    end
    n_checks++;
    if (cyc != 0) begin
      n_errors++;
      $display("FAIL no_timeout: %0d bad cycles of 80 (pool_en=%b res_valid=%b err=%b) want 0",
               cyc, bus.pool_en, bus.res_valid, err);
    end
    serve_window(0, 1, 0, 1'b0, got);
    serve_window(1, 2, 0, 1'b0, got);
    if (MIN_VAL == got) cyc = 1;
`endif
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_ramp();
    test_negative();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_wait();
    test_reset_fill();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
